// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus memory-bus arbiter.
package mips_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Fetches always move a full word.
    localparam logic [3:0] BE_FULL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RDWAIT,
        RESP
    } state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

endpackage

// File: rtl/mips_rr_arbiter.sv
// Two-way round-robin pick between fetch (I) and data (D) requesters.
module mips_rr_arbiter
    import mips_bus_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  grant_t     last_grant,
    output logic [1:0] gnt          // bit 0 = I, bit 1 = D
);

    always_comb begin
        gnt = '0;
        if (req_i && req_d) begin
            // On a tie the requester that was not served last wins.
            if (last_grant == GNT_D) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (req_i) begin
            gnt = 2'b01;
        end else if (req_d) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style memory bus between instruction fetch and data access.
// One transfer at a time; bus outputs come from registers latched at grant.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1
)(
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    output logic [DATA_W-1:0] i_readdata,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [3:0]        d_byteenable,
    output logic              d_waitrequest,
    output logic [DATA_W-1:0] d_readdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int             CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY);

    state_t           state;
    state_t           state_nxt;
    grant_t           last_grant;
    logic [CNT_W-1:0] lat_cnt;
    logic [1:0]       gnt;

    mips_rr_arbiter u_rr (
        .req_i      (i_read),
        .req_d      (d_read | d_write),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt != 2'b00) state_nxt = BUSY;
            BUSY:    if (!mem_waitrequest) state_nxt = mem_write ? RESP : RDWAIT;
            RDWAIT:  if (lat_cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant doubles as the owner of the transfer in flight.
    always_comb begin
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        if (state == RESP) begin
            if (last_grant == GNT_I) begin
                i_waitrequest = 1'b0;
            end else begin
                d_waitrequest = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            i_readdata     <= '0;
            d_readdata     <= '0;
            last_grant     <= GNT_D;
            lat_cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt[0]) begin
                        mem_address    <= i_address;
                        mem_byteenable <= BE_FULL;
                        mem_writedata  <= '0;
                        mem_read       <= 1'b1;
                        mem_write      <= 1'b0;
                        last_grant     <= GNT_I;
                    end else if (gnt[1]) begin
                        // A simultaneous read and write from D is treated as a write.
                        mem_address    <= d_address;
                        mem_byteenable <= d_byteenable;
                        mem_writedata  <= d_writedata;
                        mem_read       <= ~d_write;
                        mem_write      <= d_write;
                        last_grant     <= GNT_D;
                    end
                end
                BUSY: begin
                    if (!mem_waitrequest) begin
                        if (mem_read) begin
                            lat_cnt <= LAT_INIT;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                RDWAIT: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        if (last_grant == GNT_I) begin
                            i_readdata <= mem_readdata;
                        end else begin
                            d_readdata <= mem_readdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: two instances (READ_LATENCY 1 and 3) checked
// every cycle against a transaction-timestamp model and a latency-aware memory.
module tb_mips_bus_arbiter;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address, d_address, d_writedata;
    logic        i_read, d_read, d_write;
    logic [3:0]  d_byteenable;
    logic        mem_waitrequest;

    logic        iw [NI];
    logic        dw [NI];
    logic        mr [NI];
    logic        mw [NI];
    logic [31:0] ird [NI];
    logic [31:0] drd [NI];
    logic [31:0] maddr [NI];
    logic [31:0] mwd [NI];
    logic [31:0] mrd [NI];
    logic [3:0]  mbe [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mips_bus_arbiter #(
            .ADDR_W       (32),
            .DATA_W       (32),
            .READ_LATENCY (g == 0 ? 1 : 3)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .i_address       (i_address),
            .i_read          (i_read),
            .i_waitrequest   (iw[g]),
            .i_readdata      (ird[g]),
            .d_address       (d_address),
            .d_read          (d_read),
            .d_write         (d_write),
            .d_writedata     (d_writedata),
            .d_byteenable    (d_byteenable),
            .d_waitrequest   (dw[g]),
            .d_readdata      (drd[g]),
            .mem_address     (maddr[g]),
            .mem_read        (mr[g]),
            .mem_write       (mw[g]),
            .mem_writedata   (mwd[g]),
            .mem_byteenable  (mbe[g]),
            .mem_waitrequest (mem_waitrequest),
            .mem_readdata    (mrd[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one in-flight transaction described by timestamps.
    bit          m_busy [NI];
    bit          m_acc [NI];
    bit          m_own_d [NI];
    bit          m_wr [NI];
    bit          m_last_d [NI];
    int          m_resp [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_wd [NI];
    logic [3:0]  m_be [NI];
    logic [31:0] m_ird [NI];
    logic [31:0] m_drd [NI];

    // Memory slave: accepted read addresses travel down a delay line.
    bit          pv [NI][8];
    logic [31:0] pa [NI][8];
    bit          o_mr [NI];
    bit          o_mw [NI];
    logic [31:0] o_addr [NI];
    bit          new_grant [NI];

    int seen [NI];
    int mr_cnt [NI];
    int mw_cnt [NI];
    int ngr [NI];
    bit exp_d [NI];

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h3C02_0000;
            32'hBFC0_0020: return 32'hDEAD_BEEF;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5555_AAAA;
        endcase
    endfunction

    task automatic check_val(input string tag, input int inst,
                             input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[lat%0d] cyc %0d: got %h expected %h",
                     tag, lat_of(inst), cyc, got, exp);
        end
    endtask

    task automatic reset_model(input int g);
        m_busy[g]   = 1'b0;
        m_acc[g]    = 1'b0;
        m_own_d[g]  = 1'b0;
        m_wr[g]     = 1'b0;
        m_last_d[g] = 1'b1;
        m_resp[g]   = -1;
        m_ird[g]    = '0;
        m_drd[g]    = '0;
        for (int k = 0; k < 8; k++) begin
            pv[g][k] = 1'b0;
            pa[g][k] = '0;
        end
    endtask

    // Advance the model across one clock edge using the inputs of the ending cycle.
    task automatic edge_model(input int g);
        bit pi, pd, take_d;
        if (m_busy[g]) begin
            if (cyc - 1 == m_resp[g]) begin
                m_busy[g] = 1'b0;
            end else if (!m_acc[g] && !mem_waitrequest) begin
                m_acc[g]  = 1'b1;
                m_resp[g] = m_wr[g] ? cyc : cyc + lat_of(g);
            end
        end else begin
            pi = i_read;
            pd = d_read | d_write;
            if (pi || pd) begin
                take_d      = pd && !(pi && m_last_d[g]);
                m_busy[g]   = 1'b1;
                m_acc[g]    = 1'b0;
                m_resp[g]   = -1;
                m_own_d[g]  = take_d;
                m_last_d[g] = take_d;
                if (take_d) begin
                    m_wr[g]   = d_write;
                    m_addr[g] = d_address;
                    m_wd[g]   = d_writedata;
                    m_be[g]   = d_byteenable;
                end else begin
                    m_wr[g]   = 1'b0;
                    m_addr[g] = i_address;
                    m_wd[g]   = '0;
                    m_be[g]   = 4'hF;
                end
            end
        end
        if (m_busy[g] && m_acc[g] && !m_wr[g] && m_resp[g] == cyc) begin
            if (m_own_d[g]) m_drd[g] = memf(m_addr[g]);
            else            m_ird[g] = memf(m_addr[g]);
        end
    endtask

    task automatic compare(input int g);
        bit in_req, resp_now;
        in_req   = m_busy[g] && !m_acc[g];
        resp_now = m_busy[g] && m_acc[g] && (m_resp[g] == cyc);
        check_val("i_waitrequest", g, iw[g], !(resp_now && !m_own_d[g]));
        check_val("d_waitrequest", g, dw[g], !(resp_now && m_own_d[g]));
        check_val("mem_read", g, mr[g], in_req && !m_wr[g]);
        check_val("mem_write", g, mw[g], in_req && m_wr[g]);
        check_val("i_readdata", g, ird[g], m_ird[g]);
        check_val("d_readdata", g, drd[g], m_drd[g]);
        if (in_req) begin
            check_val("mem_address", g, maddr[g], m_addr[g]);
            check_val("mem_byteenable", g, mbe[g], m_be[g]);
            check_val("mem_writedata", g, mwd[g], m_wd[g]);
        end
    endtask

    task automatic cycle();
        int l;
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < NI; g++) begin
            if (!reset) reset_model(g);
            else        edge_model(g);
            compare(g);
            for (int k = 7; k > 0; k--) begin
                pv[g][k] = pv[g][k-1];
                pa[g][k] = pa[g][k-1];
            end
            pv[g][0] = reset && o_mr[g] && !mem_waitrequest;
            pa[g][0] = o_addr[g];
            l = lat_of(g);
            mrd[g] = pv[g][l-1] ? memf(pa[g][l-1]) : $urandom();
            new_grant[g] = (mr[g] || mw[g]) && !(o_mr[g] || o_mw[g]);
            o_mr[g]   = mr[g];
            o_mw[g]   = mw[g];
            o_addr[g] = maddr[g];
        end
    endtask

    task automatic check_reset_vals();
        for (int g = 0; g < NI; g++) begin
            check_val("rst_mem_read", g, mr[g], 1'b0);
            check_val("rst_mem_write", g, mw[g], 1'b0);
            check_val("rst_i_wait", g, iw[g], 1'b1);
            check_val("rst_d_wait", g, dw[g], 1'b1);
            check_val("rst_i_rdata", g, ird[g], 32'h0);
            check_val("rst_d_rdata", g, drd[g], 32'h0);
            check_val("rst_mem_addr", g, maddr[g], 32'h0);
            check_val("rst_mem_be", g, mbe[g], 32'h0);
            check_val("rst_mem_wdata", g, mwd[g], 32'h0);
        end
    endtask

    // Requests are presented by the caller in cycle 1 and dropped after the grant edge.
    task automatic wait_done(input bit want_d, input int hold_end);
        int n;
        n = 1;
        for (int g = 0; g < NI; g++) begin
            seen[g]   = 0;
            mr_cnt[g] = 0;
            mw_cnt[g] = 0;
        end
        mem_waitrequest = (hold_end >= 1);
        for (int k = 0; k < 40 && !(seen[0] != 0 && seen[1] != 0); k++) begin
            cycle();
            n++;
            i_read  = 1'b0;
            d_read  = 1'b0;
            d_write = 1'b0;
            mem_waitrequest = (n <= hold_end);
            for (int g = 0; g < NI; g++) begin
                mr_cnt[g] += int'(mr[g]);
                mw_cnt[g] += int'(mw[g]);
                if (seen[g] == 0 && (want_d ? dw[g] : iw[g]) == 1'b0) seen[g] = n;
            end
        end
        mem_waitrequest = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        for (int g = 0; g < NI; g++) reset_model(g);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        i_address = '0; d_address = '0; d_writedata = '0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        d_byteenable = '0; mem_waitrequest = 1'b0;
        for (int g = 0; g < NI; g++) begin
            reset_model(g);
            mrd[g] = '0; o_mr[g] = 1'b0; o_mw[g] = 1'b0; o_addr[g] = '0;
        end
        cycle();
        check_reset_vals();
        reset = 1'b1;
        cycle();

        // Fetch only.
        i_address = 32'hBFC0_0000; i_read = 1'b1;
        wait_done(1'b0, 0);
        for (int g = 0; g < NI; g++) begin
            check_val("t1_latency", g, seen[g], 3 + lat_of(g));
            check_val("t1_rdata", g, ird[g], 32'h3C02_0000);
            check_val("t1_rd_cycles", g, mr_cnt[g], 1);
        end

        // Store only.
        d_address = 32'hBFC0_0010; d_writedata = 32'h0000_FFF0;
        d_byteenable = 4'b0011; d_write = 1'b1;
        wait_done(1'b1, 0);
        for (int g = 0; g < NI; g++) begin
            check_val("t2_latency", g, seen[g], 3);
            check_val("t2_wr_cycles", g, mw_cnt[g], 1);
        end

        // Both pending continuously from reset: grants must alternate, I first.
        apply_reset();
        i_address = 32'h0000_0100; d_address = 32'h0000_0200;
        d_byteenable = 4'hF; i_read = 1'b1; d_read = 1'b1;
        for (int g = 0; g < NI; g++) begin
            exp_d[g] = 1'b0;
            ngr[g]   = 0;
        end
        repeat (30) begin
            cycle();
            for (int g = 0; g < NI; g++) begin
                if (new_grant[g]) begin
                    check_val("t3_grant_addr", g, maddr[g],
                              exp_d[g] ? 32'h0000_0200 : 32'h0000_0100);
                    exp_d[g] = !exp_d[g];
                    ngr[g]++;
                end
            end
        end
        for (int g = 0; g < NI; g++) check_val("t3_grant_count", g, ngr[g] >= 4, 1'b1);
        i_read = 1'b0; d_read = 1'b0;
        repeat (8) cycle();

        // Bus stall for 5 cycles in BUSY.
        i_address = 32'hBFC0_0000; i_read = 1'b1;
        wait_done(1'b0, 6);
        for (int g = 0; g < NI; g++) begin
            check_val("t4_latency", g, seen[g], 8 + lat_of(g));
            check_val("t4_rdata", g, ird[g], 32'h3C02_0000);
        end

        // Asynchronous reset while both instances are in the read-wait phase.
        i_address = 32'h0000_0400; i_read = 1'b1;
        cycle();
        i_read = 1'b0;
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals();
        for (int g = 0; g < NI; g++) reset_model(g);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        i_address = 32'hBFC0_0000; i_read = 1'b1;
        wait_done(1'b0, 0);
        for (int g = 0; g < NI; g++) begin
            check_val("t5_latency", g, seen[g], 3 + lat_of(g));
            check_val("t5_rdata", g, ird[g], 32'h3C02_0000);
        end

        // Data load, then read+write together issues only a write.
        d_address = 32'hBFC0_0020; d_byteenable = 4'hF; d_read = 1'b1;
        wait_done(1'b1, 0);
        for (int g = 0; g < NI; g++) begin
            check_val("t6_latency", g, seen[g], 3 + lat_of(g));
            check_val("t6_rdata", g, drd[g], 32'hDEAD_BEEF);
        end
        d_address = 32'hBFC0_0030; d_writedata = 32'h1234_5678;
        d_read = 1'b1; d_write = 1'b1;
        wait_done(1'b1, 0);
        for (int g = 0; g < NI; g++) begin
            check_val("t6_rw_latency", g, seen[g], 3);
            check_val("t6_rw_reads", g, mr_cnt[g], 0);
            check_val("t6_rw_writes", g, mw_cnt[g], 1);
            check_val("t6_rdata_kept", g, drd[g], 32'hDEAD_BEEF);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 2500; k++) begin
            i_read          = ($urandom_range(0, 2) == 0);
            i_address       = $urandom() & 32'hFFFF_FFFC;
            d_read          = ($urandom_range(0, 3) == 0);
            d_write         = ($urandom_range(0, 3) == 0);
            d_address       = $urandom();
            d_writedata     = $urandom();
            d_byteenable    = 4'($urandom_range(0, 15));
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
